// File: rtl/bram_stream_loader_if.sv
// Command, byte-stream, RAM write-port and status signals of the stream loader.
// The loader sits on the slave side; the host or bench drives the master side.
interface bram_stream_loader_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int LEN_W  = ADDR_W + 1
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [LEN_W-1:0]  length;
   logic              abort;
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic              busy;
   logic              done;
   logic              aborted;
   logic [LEN_W-1:0]  byte_count;
   logic [DATA_W-1:0] checksum;

   modport master (
      output start, base_addr, length, abort, s_data, s_valid,
      input  s_ready, mem_we, mem_addr, mem_din, busy, done, aborted, byte_count, checksum
   );

   modport slave (
      input  start, base_addr, length, abort, s_data, s_valid,
      output s_ready, mem_we, mem_addr, mem_din, busy, done, aborted, byte_count, checksum
   );
endinterface

// File: rtl/bram_stream_loader.sv
// Fills a RAM write port from a valid/ready byte stream: base address + length
// command, one registered write per accepted byte, byte count and additive checksum.
module bram_stream_loader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int LEN_W  = ADDR_W + 1
) (
   input logic                  clk,
   input logic                  rst_n,
   bram_stream_loader_if.slave  bus
);
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

   logic [1:0]        state_r;
   logic [ADDR_W-1:0] ptr_r;
   logic [LEN_W-1:0]  len_r;
   logic [LEN_W-1:0]  count_r;
   logic [DATA_W-1:0] sum_r;
   logic              aborted_r;
   logic              we_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] din_r;

   logic              ready_s;
   logic              xfer_s;
   logic [LEN_W-1:0]  count_next_s;

   // Handshake: abort wins over a byte offered in the same cycle.
   always_comb begin
      ready_s      = (state_r == ST_LOAD) && !bus.abort;
      xfer_s       = ready_s && bus.s_valid;
      count_next_s = count_r + {{(LEN_W-1){1'b0}}, 1'b1};
   end

   // Sequencer, write-port registers and running statistics.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         ptr_r     <= {ADDR_W{1'b0}};
         len_r     <= {LEN_W{1'b0}};
         count_r   <= {LEN_W{1'b0}};
         sum_r     <= {DATA_W{1'b0}};
         aborted_r <= 1'b0;
         we_r      <= 1'b0;
         addr_r    <= {ADDR_W{1'b0}};
         din_r     <= {DATA_W{1'b0}};
      end else begin
         we_r <= xfer_s;
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  ptr_r     <= bus.base_addr;
                  len_r     <= bus.length;
                  count_r   <= {LEN_W{1'b0}};
                  sum_r     <= {DATA_W{1'b0}};
                  aborted_r <= 1'b0;
                  state_r   <= (bus.length == {LEN_W{1'b0}}) ? ST_FINISH : ST_LOAD;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               if (bus.abort) begin
                  aborted_r <= 1'b1;
                  state_r   <= ST_IDLE;
               end else if (xfer_s) begin
                  addr_r  <= ptr_r;
                  din_r   <= bus.s_data;
                  ptr_r   <= ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                  count_r <= count_next_s;
                  sum_r   <= sum_r + bus.s_data;
                  state_r <= (count_next_s == len_r) ? ST_FINISH : ST_LOAD;
               end else begin
                  state_r <= ST_LOAD;
               end
            end
            ST_FINISH: state_r <= ST_IDLE;
            default:   state_r <= ST_IDLE;
         endcase
      end
   end

   // Status is decoded from the state register, so it is glitch-free.
   assign bus.s_ready    = ready_s;
   assign bus.busy       = (state_r == ST_LOAD);
   assign bus.done       = (state_r == ST_FINISH);
   assign bus.aborted    = aborted_r;
   assign bus.mem_we     = we_r;
   assign bus.mem_addr   = addr_r;
   assign bus.mem_din    = din_r;
   assign bus.byte_count = count_r;
   assign bus.checksum   = sum_r;
endmodule
